// File: rtl/fpu_addsub_sched.sv
// ---------------------------------------------------------------------------
// fpu_addsub_sched
//
// Shares one combinational floating-point add/sub datapath between NReq
// requesters. A round-robin arbiter picks one requester per accept cycle.
// Its operands are registered onto the datapath inputs for one cycle, and the
// result is captured into a tagged response register. The response is then
// returned through a valid/ready handshake. Only one operation is in flight
// at a time.
//
// Ports
//   clk_i, rst_ni           clock (rising edge), asynchronous active-low reset
//   req_valid_i [NReq]      requester i has an operation pending
//   req_ready_o [NReq]      one-hot grant, asserted only in accept cycles
//   req_sub_i   [NReq]      1 = in1 - in2, 0 = in1 + in2
//   req_in1_i/req_in2_i     packed operands, requester i at [i*FpW +: FpW]
//   au_sub_o/au_in1_o/au_in2_o  registered operands to the datapath
//   au_out_i/au_cc_i/au_flags_i result, {Z,C,N,V} and status flags from datapath
//   rsp_valid_o/rsp_ready_i response handshake
//   rsp_id_o                tag of the requester that issued the operation
//   rsp_out_o/rsp_cc_o/rsp_flags_o  captured result fields
//   busy_o                  scheduler is not idle
// ---------------------------------------------------------------------------
module fpu_addsub_sched #(
    parameter int unsigned NReq = 4,
    parameter type         FpT  = logic [15:0],
    localparam int unsigned FpW = $bits(FpT),
    localparam int unsigned IdW = (NReq > 1) ? $clog2(NReq) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NReq-1:0]     req_valid_i,
    output logic [NReq-1:0]     req_ready_o,
    input  logic [NReq-1:0]     req_sub_i,
    input  logic [NReq*FpW-1:0] req_in1_i,
    input  logic [NReq*FpW-1:0] req_in2_i,
    output logic                au_sub_o,
    output logic [FpW-1:0]      au_in1_o,
    output logic [FpW-1:0]      au_in2_o,
    input  logic [FpW-1:0]      au_out_i,
    input  logic [3:0]          au_cc_i,
    input  logic [4:0]          au_flags_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [IdW-1:0]      rsp_id_o,
    output logic [FpW-1:0]      rsp_out_o,
    output logic [3:0]          rsp_cc_o,
    output logic [4:0]          rsp_flags_o,
    output logic                busy_o
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [IdW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IdW-1:0] tag_q, tag_d;
    logic           au_sub_q, au_sub_d;
    logic [FpW-1:0] au_in1_q, au_in1_d;
    logic [FpW-1:0] au_in2_q, au_in2_d;
    logic [IdW-1:0] rsp_id_q, rsp_id_d;
    logic [FpW-1:0] rsp_out_q, rsp_out_d;
    logic [3:0]     rsp_cc_q, rsp_cc_d;
    logic [4:0]     rsp_flags_q, rsp_flags_d;

    logic           accept;
    logic           grant_found;
    logic [IdW-1:0] grant_idx;
    logic [IdW-1:0] cand;

    // A new operation may start when idle, or when the pending response is
    // being consumed in this same cycle (back-to-back issue).
    assign accept = (state_q == StIdle) || ((state_q == StDone) && rsp_ready_i);

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned k = 1; k <= NReq; k++) begin
            cand = IdW'((32'(rr_ptr_q) + k) % NReq);
            if (!grant_found && req_valid_i[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (accept && grant_found) begin
            req_ready_o = NReq'(1) << grant_idx;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        tag_d       = tag_q;
        au_sub_d    = au_sub_q;
        au_in1_d    = au_in1_q;
        au_in2_d    = au_in2_q;
        rsp_id_d    = rsp_id_q;
        rsp_out_d   = rsp_out_q;
        rsp_cc_d    = rsp_cc_q;
        rsp_flags_d = rsp_flags_q;

        unique case (state_q)
            StIdle: state_d = StIdle;
            StExec: begin
                // Operands have been stable on au_* for this whole cycle.
                rsp_id_d    = tag_q;
                rsp_out_d   = au_out_i;
                rsp_cc_d    = au_cc_i;
                rsp_flags_d = au_flags_i;
                state_d     = StDone;
            end
            StDone: begin
                if (rsp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (accept && grant_found) begin
            state_d  = StExec;
            rr_ptr_d = grant_idx;
            tag_d    = grant_idx;
            au_sub_d = req_sub_i[grant_idx];
            au_in1_d = req_in1_i[32'(grant_idx) * FpW +: FpW];
            au_in2_d = req_in2_i[32'(grant_idx) * FpW +: FpW];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            rr_ptr_q    <= IdW'(NReq - 1);
            tag_q       <= '0;
            au_sub_q    <= 1'b0;
            au_in1_q    <= '0;
            au_in2_q    <= '0;
            rsp_id_q    <= '0;
            rsp_out_q   <= '0;
            rsp_cc_q    <= '0;
            rsp_flags_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            tag_q       <= tag_d;
            au_sub_q    <= au_sub_d;
            au_in1_q    <= au_in1_d;
            au_in2_q    <= au_in2_d;
            rsp_id_q    <= rsp_id_d;
            rsp_out_q   <= rsp_out_d;
            rsp_cc_q    <= rsp_cc_d;
            rsp_flags_q <= rsp_flags_d;
        end
    end

    assign au_sub_o    = au_sub_q;
    assign au_in1_o    = au_in1_q;
    assign au_in2_o    = au_in2_q;
    assign rsp_valid_o = (state_q == StDone);
    assign rsp_id_o    = rsp_id_q;
    assign rsp_out_o   = rsp_out_q;
    assign rsp_cc_o    = rsp_cc_q;
    assign rsp_flags_o = rsp_flags_q;
    assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_fpu_addsub_sched.sv
// ---------------------------------------------------------------------------
// tb_fpu_addsub_sched
//
// Directed bench for fpu_addsub_sched. A small table stands in for the fp16
// add/sub datapath. Expected responses are pushed into a queue as operations
// are issued, and a monitor pops and compares them whenever a response is
// handed over.
// ---------------------------------------------------------------------------
module tb_fpu_addsub_sched;

    localparam int NReq = 4;

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] out;
        logic [3:0]  cc;
        logic [4:0]  flags;
    } rsp_t;

    logic        clk_i;
    logic        rst_ni;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [3:0]  req_sub;
    logic [63:0] req_in1;
    logic [63:0] req_in2;
    logic        au_sub;
    logic [15:0] au_in1;
    logic [15:0] au_in2;
    logic [15:0] au_out;
    logic [3:0]  au_cc;
    logic [4:0]  au_flags;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_out;
    logic [3:0]  rsp_cc;
    logic [4:0]  rsp_flags;
    logic        busy;

    int   checks = 0;
    int   errors = 0;
    rsp_t exp_q[$];
    int   grant_log[$];

    fpu_addsub_sched #(
        .NReq (NReq)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_sub_i   (req_sub),
        .req_in1_i   (req_in1),
        .req_in2_i   (req_in2),
        .au_sub_o    (au_sub),
        .au_in1_o    (au_in1),
        .au_in2_o    (au_in2),
        .au_out_i    (au_out),
        .au_cc_i     (au_cc),
        .au_flags_i  (au_flags),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_id_o    (rsp_id),
        .rsp_out_o   (rsp_out),
        .rsp_cc_o    (rsp_cc),
        .rsp_flags_o (rsp_flags),
        .busy_o      (busy)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Datapath stand-in: fp16 results for the operand pairs the bench uses.
    // cc = {Z,C,N,V}; flag bit 0 is used here as "inexact".
    always_comb begin
        au_out   = 16'hDEAD;
        au_cc    = 4'hF;
        au_flags = 5'h1F;
        case ({au_sub, au_in1, au_in2})
            {1'b0, 16'h3C00, 16'h4000}: begin au_out = 16'h4200; au_cc = 4'b0000; au_flags = 5'h00; end
            {1'b0, 16'h3C00, 16'h3C00}: begin au_out = 16'h4000; au_cc = 4'b0000; au_flags = 5'h00; end
            {1'b0, 16'h4000, 16'h4000}: begin au_out = 16'h4400; au_cc = 4'b0000; au_flags = 5'h00; end
            {1'b0, 16'h3800, 16'h3800}: begin au_out = 16'h3C00; au_cc = 4'b0000; au_flags = 5'h00; end
            {1'b0, 16'h3C00, 16'h0001}: begin au_out = 16'h3C00; au_cc = 4'b0000; au_flags = 5'h01; end
            {1'b1, 16'h4200, 16'h4200}: begin au_out = 16'h0000; au_cc = 4'b1000; au_flags = 5'h00; end
            {1'b1, 16'h4400, 16'h3C00}: begin au_out = 16'h4200; au_cc = 4'b0000; au_flags = 5'h00; end
            {1'b1, 16'h3C00, 16'h4000}: begin au_out = 16'hBC00; au_cc = 4'b0010; au_flags = 5'h00; end
            default: ;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Response scoreboard.
    always @(negedge clk_i) begin
        if (rst_ni && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got id %0d out 0x%0h, expected no response",
                         rsp_id, rsp_out);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                check("rsp_id", 32'(rsp_id), 32'(e.id));
                check("rsp_out", 32'(rsp_out), 32'(e.out));
                check("rsp_cc", 32'(rsp_cc), 32'(e.cc));
                check("rsp_flags", 32'(rsp_flags), 32'(e.flags));
            end
        end
    end

    // Grant monitor: one-hot and log of granted indices.
    always @(negedge clk_i) begin
        if (rst_ni && req_ready != 4'b0000) begin
            check("grant_onehot", 32'($onehot(req_ready)), 32'd1);
            for (int i = 0; i < NReq; i++) begin
                if (req_ready[i]) grant_log.push_back(i);
            end
        end
    end

    task automatic push_exp(input int id, input logic [15:0] o, input logic [3:0] c,
                            input logic [4:0] f);
        rsp_t e;
        e.id    = 2'(id);
        e.out   = o;
        e.cc    = c;
        e.flags = f;
        exp_q.push_back(e);
    endtask

    task automatic set_req(input int id, input logic s, input logic [15:0] a,
                           input logic [15:0] b);
        req_sub[id]          = s;
        req_in1[id*16 +: 16] = a;
        req_in2[id*16 +: 16] = b;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_grant(input int id);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk_i);
            if (req_ready[id]) seen = 1'b1;
        end
        check($sformatf("grant_req%0d", id), 32'(seen), 32'd1);
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 30 && !done; n++) begin
            @(negedge clk_i);
            if (exp_q.size() == 0 && !busy) done = 1'b1;
        end
        check("drain", 32'(done), 32'd1);
        step();
    endtask

    task automatic do_single(input int id, input logic s, input logic [15:0] a,
                             input logic [15:0] b, input logic [15:0] eo,
                             input logic [3:0] ec, input logic [4:0] ef);
        push_exp(id, eo, ec, ef);
        set_req(id, s, a, b);
        req_valid[id] = 1'b1;
        wait_grant(id);
        step();
        req_valid[id] = 1'b0;
        @(negedge clk_i);
        check("exec_no_rsp", 32'(rsp_valid), 32'd0);
        check("exec_busy", 32'(busy), 32'd1);
        check("au_in1", 32'(au_in1), 32'(a));
        check("au_in2", 32'(au_in2), 32'(b));
        check("au_sub", 32'(au_sub), 32'(s));
        @(negedge clk_i);
        check("latency_rsp_valid", 32'(rsp_valid), 32'd1);
        step();
    endtask

    initial begin
        int rr_order[5];
        int n;
        rr_order  = '{0, 1, 2, 3, 0};
        rst_ni    = 1'b0;
        req_valid = '0;
        req_sub   = '0;
        req_in1   = '0;
        req_in2   = '0;
        rsp_ready = 1'b1;

        // Reset state.
        repeat (2) @(negedge clk_i);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_au_in1", 32'(au_in1), 32'd0);
        check("rst_au_sub", 32'(au_sub), 32'd0);
        check("rst_rsp_out", 32'(rsp_out), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        rst_ni = 1'b1;
        step();

        // Reset while an operation is in EXEC: no response may ever appear.
        set_req(1, 1'b0, 16'h3C00, 16'h3C00);
        req_valid[1] = 1'b1;
        wait_grant(1);
        step();
        req_valid[1] = 1'b0;
        rst_ni       = 1'b0;
        @(negedge clk_i);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_au_in1", 32'(au_in1), 32'd0);
        check("midrst_req_ready", 32'(req_ready), 32'd0);
        rst_ni = 1'b1;
        repeat (4) step();
        check("midrst_idle", 32'(busy), 32'd0);

        // Single add and subtract to zero.
        do_single(0, 1'b0, 16'h3C00, 16'h4000, 16'h4200, 4'b0000, 5'h00);
        do_single(2, 1'b1, 16'h4200, 16'h4200, 16'h0000, 4'b1000, 5'h00);
        // Moves the round-robin pointer to 3 so the next search starts at 0.
        do_single(3, 1'b1, 16'h4400, 16'h3C00, 16'h4200, 4'b0000, 5'h00);

        // Round-robin with every requester continuously valid.
        grant_log.delete();
        push_exp(0, 16'h4200, 4'b0000, 5'h00);
        push_exp(1, 16'h3C00, 4'b0000, 5'h01);
        push_exp(2, 16'h4400, 4'b0000, 5'h00);
        push_exp(3, 16'hBC00, 4'b0010, 5'h00);
        push_exp(0, 16'h4200, 4'b0000, 5'h00);
        set_req(0, 1'b0, 16'h3C00, 16'h4000);
        set_req(1, 1'b0, 16'h3C00, 16'h0001);
        set_req(2, 1'b0, 16'h4000, 16'h4000);
        set_req(3, 1'b1, 16'h3C00, 16'h4000);
        req_valid = 4'hF;
        n = 0;
        for (int c = 0; c < 40 && n < 5; c++) begin
            @(negedge clk_i);
            if (req_ready != 4'b0000) n++;
        end
        check("rr_grant_count", 32'(n), 32'd5);
        step();
        req_valid = '0;
        drain();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("rr_order%0d", i),
                  (i < grant_log.size()) ? 32'(grant_log[i]) : 32'hFFFF_FFFF,
                  32'(rr_order[i]));
        end

        // Backpressure: response held for 5 cycles, then back-to-back grant.
        rsp_ready = 1'b0;
        push_exp(0, 16'h3C00, 4'b0000, 5'h00);
        push_exp(2, 16'h0000, 4'b1000, 5'h00);
        set_req(0, 1'b0, 16'h3800, 16'h3800);
        req_valid[0] = 1'b1;
        wait_grant(0);
        step();
        req_valid = 4'b0100;
        set_req(2, 1'b1, 16'h4200, 16'h4200);
        @(negedge clk_i);
        check("bp_exec_ready", 32'(req_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_out", 32'(rsp_out), 32'h3C00);
            check("bp_rsp_id", 32'(rsp_id), 32'd0);
            check("bp_req_ready", 32'(req_ready), 32'd0);
        end
        step();
        rsp_ready = 1'b1;
        @(negedge clk_i);
        check("bp_same_cycle_grant", 32'(req_ready), 32'b0100);
        step();
        req_valid = '0;
        drain();

        // Withdraw: requester 1 drops its request before it could be granted.
        rsp_ready = 1'b0;
        push_exp(0, 16'h4000, 4'b0000, 5'h00);
        push_exp(3, 16'h4200, 4'b0000, 5'h00);
        set_req(0, 1'b0, 16'h3C00, 16'h3C00);
        req_valid[0] = 1'b1;
        wait_grant(0);
        step();
        req_valid = 4'b0010;
        set_req(1, 1'b0, 16'h4000, 16'h4000);
        @(negedge clk_i);
        check("wd_exec_ready", 32'(req_ready), 32'd0);
        @(negedge clk_i);
        check("wd_done_ready", 32'(req_ready), 32'd0);
        step();
        req_valid = 4'b1000;
        set_req(3, 1'b1, 16'h4400, 16'h3C00);
        @(negedge clk_i);
        check("wd_stall_ready", 32'(req_ready), 32'd0);
        step();
        rsp_ready = 1'b1;
        @(negedge clk_i);
        check("wd_grant3", 32'(req_ready), 32'b1000);
        step();
        req_valid = '0;
        drain();

        repeat (5) step();
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        check("final_idle", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
